// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    XFER = 2'd2
  } arb_state_e;

  // Per-grant byte counter width; bounds MAX_BURST to 65535.
  localparam int BURST_CNT_W = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rr_prio_enc.sv
// Round-robin priority encoder: picks the first requester after 'last',
// wrapping modulo PORTS. Purely combinational.
module uart_rr_prio_enc
  import uart_arb_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int IDX_W = clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan from the farthest offset down so the nearest requester after 'last' wins.
  always_comb begin
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = PORTS; off >= 1; off--) begin
      cand     = (int'(last) + off) % PORTS;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        gnt_idx = cand_idx;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI4-Stream UART transmitter
// among PORTS byte producers, with a registered output stage.
// Optional feature: define UART_TX_ARB_HDR_EN to prefix every grant with a
// one-byte header carrying the granted port index.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  input  logic [PORTS-1:0]            s_axis_tlast,
  output logic [PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic                        grant_valid,
  output logic [clog2(PORTS)-1:0]     grant_idx
);

  localparam int IDX_W = clog2(PORTS);

  arb_state_e             state_q,       state_d;
  logic [IDX_W-1:0]       grant_idx_q,   grant_idx_d;
  logic                   grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]       last_grant_q,  last_grant_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q,   burst_cnt_d;
  logic [DATA_WIDTH-1:0]  m_tdata_q,     m_tdata_d;
  logic                   m_tvalid_q,    m_tvalid_d;
  logic                   m_tlast_q,     m_tlast_d;

  logic [IDX_W-1:0]       enc_idx;
  logic                   enc_any;
  logic                   out_free;
  logic [DATA_WIDTH-1:0]  g_data;
  logic                   g_valid;
  logic                   g_last;
  logic                   accept;
  logic                   rel;
  logic [BURST_CNT_W-1:0] burst_inc;

  uart_rr_prio_enc #(
    .PORTS (PORTS),
    .IDX_W (IDX_W)
  ) u_enc (
    .req     (s_axis_tvalid),
    .last    (last_grant_q),
    .gnt_idx (enc_idx),
    .gnt_any (enc_any)
  );

  // Output slot can take a byte when empty or draining this cycle.
  assign out_free  = ~m_tvalid_q | m_axis_tready;
  assign g_data    = s_axis_tdata[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign g_valid   = s_axis_tvalid[grant_idx_q];
  assign g_last    = s_axis_tlast[grant_idx_q];
  assign accept    = (state_q == XFER) & g_valid & out_free;
  assign burst_inc = burst_cnt_q + BURST_CNT_W'(1);
  // A byte carrying tlast on the MAX_BURST-th beat releases only once.
  assign rel       = accept & (g_last | (burst_inc == BURST_CNT_W'(MAX_BURST)));

  // Only the granted port sees ready, and only while transferring payload.
  always_comb begin
    s_axis_tready = '0;
    if (state_q == XFER) s_axis_tready[grant_idx_q] = out_free;
  end

  // Next-state for grant control, burst counter and the output register.
  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    last_grant_d  = last_grant_q;
    burst_cnt_d   = burst_cnt_q;
    m_tdata_d     = m_tdata_q;
    m_tlast_d     = m_tlast_q;
    m_tvalid_d    = m_tvalid_q & ~m_axis_tready;
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          grant_idx_d   = enc_idx;
          grant_valid_d = 1'b1;
`ifdef UART_TX_ARB_HDR_EN
          state_d       = HDR;
`else
          state_d       = XFER;
`endif
        end
      end
`ifdef UART_TX_ARB_HDR_EN
      HDR: begin
        if (out_free) begin
          m_tdata_d  = DATA_WIDTH'(grant_idx_q);
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b0;
          state_d    = XFER;
        end
      end
`endif
      XFER: begin
        if (accept) begin
          m_tdata_d   = g_data;
          m_tvalid_d  = 1'b1;
          m_tlast_d   = rel;
          burst_cnt_d = burst_inc;
          if (rel) begin
            state_d       = IDLE;
            last_grant_d  = grant_idx_q;
            grant_valid_d = 1'b0;
            burst_cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      last_grant_q  <= IDX_W'(PORTS - 1);
      burst_cnt_q   <= '0;
      m_tdata_q     <= '0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      last_grant_q  <= last_grant_d;
      burst_cnt_q   <= burst_cnt_d;
      m_tdata_q     <= m_tdata_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign grant_valid   = grant_valid_q;
  assign grant_idx     = grant_idx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (PORTS=4, 8-bit bytes, MAX_BURST=4).
// Per-port source queues feed the slave side; every output beat is logged
// with its grant index and cycle, then compared to hand-built expectations.
module tb_uart_tx_arbiter;

  localparam int PORTS = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
`ifdef UART_TX_ARB_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [PORTS*DW-1:0]   s_axis_tdata;
  logic [PORTS-1:0]      s_axis_tvalid;
  logic [PORTS-1:0]      s_axis_tlast;
  logic [PORTS-1:0]      s_axis_tready;
  logic [DW-1:0]         m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tlast;
  logic                  m_axis_tready;
  logic                  grant_valid;
  logic [1:0]            grant_idx;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .PORTS      (PORTS),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx)
  );

  typedef struct {
    int port;
    int last;
    int data;
    int gap;
    int cyc;
  } beat_t;

  beat_t      got[$];
  beat_t      exp_q[$];
  logic [8:0] src[PORTS][$];
  int         cyc    = 0;
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  task automatic drive();
    for (int i = 0; i < PORTS; i++) begin
      if (src[i].size() > 0) begin
        s_axis_tvalid[i]          = 1'b1;
        s_axis_tdata[i*DW +: DW]  = src[i][0][7:0];
        s_axis_tlast[i]           = src[i][0][8];
      end else begin
        s_axis_tvalid[i]          = 1'b0;
        s_axis_tdata[i*DW +: DW]  = '0;
        s_axis_tlast[i]           = 1'b0;
      end
    end
  endtask

  task automatic push_pkt(input int port, input int d0, input int n);
    logic [8:0] e;
    for (int i = 0; i < n; i++) begin
      e = {(i == n - 1), 8'(d0 + i)};
      src[port].push_back(e);
    end
  endtask

  // Expected beats of one grant; header byte prepended when enabled.
  task automatic exp_pkt(input int port, input int d0, input int n,
                         input int g_first, input int g_in);
    beat_t b;
    int    g;
    g = g_first;
    if (HDR_EN) begin
      b = '{port, 0, port, g, 0};
      exp_q.push_back(b);
      g = g_in;
    end
    for (int i = 0; i < n; i++) begin
      b = '{port, int'(i == n - 1), d0 + i, g, 0};
      exp_q.push_back(b);
      g = g_in;
    end
  endtask

  task automatic run_check(input string tag, input int budget);
    int t;
    t = 0;
    while (got.size() < exp_q.size() && t < budget) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    chk({tag, " beats"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk($sformatf("%s[%0d] data", tag, i), got[i].data, exp_q[i].data);
      chk($sformatf("%s[%0d] last", tag, i), got[i].last, exp_q[i].last);
      chk($sformatf("%s[%0d] port", tag, i), got[i].port, exp_q[i].port);
      if (i > 0 && exp_q[i].gap != 0)
        chk($sformatf("%s[%0d] gap", tag, i), got[i].cyc - got[i-1].cyc, exp_q[i].gap);
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int p = 0; p < PORTS; p++) src[p].delete();
    drive();
    #10;
    rst = 1'b0;
    got.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " m_tvalid"},    int'(m_axis_tvalid), 0);
    chk({tag, " m_tdata"},     int'(m_axis_tdata), 0);
    chk({tag, " m_tlast"},     int'(m_axis_tlast), 0);
    chk({tag, " s_tready"},    int'(s_axis_tready), 0);
    chk({tag, " grant_valid"}, int'(grant_valid), 0);
    chk({tag, " grant_idx"},   int'(grant_idx), 0);
  endtask

  // Source/sink model: sample handshakes mid-cycle, advance queues after the edge.
  always begin
    logic [PORTS-1:0] fire;
    @(negedge clk);
    fire = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready)
      got.push_back('{int'(grant_idx), int'(m_axis_tlast), int'(m_axis_tdata), 0, cyc});
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < PORTS; i++)
      if (fire[i] && src[i].size() > 0) void'(src[i].pop_front());
    drive();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    m_axis_tready = 1'b1;
    drive();
    #1 rst = 1'b1;
    #20;
    chk_reset_outputs("reset");
    @(posedge clk);
    #3 rst = 1'b0;

    // Single port, three-byte packet at full rate.
    push_pkt(0, 'h41, 3);
    drive();
    exp_pkt(0, 'h41, 3, 0, 1);
    run_check("t1", 40);
    chk("t1 grant_valid", int'(grant_valid), 0);

    // Three ports contend; round-robin from port 0, one idle cycle between grants.
    do_reset();
    push_pkt(0, 'h10, 2);
    push_pkt(0, 'h12, 2);
    push_pkt(1, 'h20, 2);
    push_pkt(2, 'h30, 2);
    drive();
    exp_pkt(0, 'h10, 2, 0, 1);
    exp_pkt(1, 'h20, 2, 2, 1);
    exp_pkt(2, 'h30, 2, 2, 1);
    exp_pkt(0, 'h12, 2, 2, 1);
    run_check("t2", 80);

    // Forced release after MAX_BURST bytes lets port 1 in between port 3 bursts.
    do_reset();
    push_pkt(3, 'hA0, 10);
    drive();
    repeat (2) @(posedge clk);
    #3;
    push_pkt(1, 'hB0, 2);
    drive();
    exp_pkt(3, 'hA0, 4, 0, 1);
    exp_pkt(1, 'hB0, 2, 2, 1);
    exp_pkt(3, 'hA4, 4, 2, 1);
    exp_pkt(3, 'hA8, 2, 2, 1);
    run_check("t3", 120);

    // Sink stalls two cycles mid-packet; tlast on the MAX_BURST-th byte.
    do_reset();
    push_pkt(0, 'h50, 4);
    push_pkt(0, 'h54, 1);
    drive();
    exp_pkt(0, 'h50, 4, 0, 0);
    exp_pkt(0, 'h54, 1, 0, 0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!m_axis_tvalid && t < 50);
    chk("t4 first beat", int'(m_axis_tvalid), 1);
    @(posedge clk);
    #2 m_axis_tready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t4 stall data",     int'(m_axis_tdata), HDR_EN ? 'h50 : 'h51);
      chk("t4 stall valid",    int'(m_axis_tvalid), 1);
      chk("t4 stall s_tready", int'(s_axis_tready), 0);
    end
    @(posedge clk);
    #2 m_axis_tready = 1'b1;
    run_check("t4", 60);
    chk("t4 grant_valid", int'(grant_valid), 0);

    // Reset in the middle of a port 2 packet.
    do_reset();
    push_pkt(2, 'h60, 4);
    drive();
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!m_axis_tvalid && t < 50);
    chk("t5 pre-reset beat", int'(m_axis_tvalid), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_reset_outputs("t5 async");
    for (int p = 0; p < PORTS; p++) src[p].delete();
    drive();
    #10 rst = 1'b0;
    got.delete();
    exp_q.delete();
    push_pkt(3, 'h70, 1);
    push_pkt(1, 'h80, 1);
    drive();
    exp_pkt(1, 'h80, 1, 0, 0);
    exp_pkt(3, 'h70, 1, 0, 0);
    run_check("t5", 60);

`ifdef UART_TX_ARB_HDR_EN
    // Header byte carries the port index; the port is not ready meanwhile.
    do_reset();
    push_pkt(2, 'h55, 1);
    drive();
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!grant_valid && t < 50);
    chk("t6 grant_idx", int'(grant_idx), 2);
    chk("t6 hdr s_tready", int'(s_axis_tready[2]), 0);
    exp_pkt(2, 'h55, 1, 0, 1);
    run_check("t6", 40);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
